// File: rtl/mig_sweep_eval.sv
// Programmable majority-inverter-graph evaluator: a chain of maj() nodes loaded
// through a config port, evaluated on single vectors or swept over all inputs.

module mig_node #(
  parameter int SRC_W = 8,
  parameter int SEL_W = 4
) (
  input  logic [SRC_W-1:0]      i_src,
  input  logic [2:0][SEL_W-1:0] i_sel,
  input  logic [2:0]            i_inv,
  output logic                  o_y
);
  logic [2:0] w_op;

  // Selectors past the visible sources (forward node refs, out of range) read 0.
  always_comb begin
    w_op = '0;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < SRC_W; i++)
        if (i_sel[s] == SEL_W'(i)) w_op[s] = i_src[i];
      w_op[s] = w_op[s] ^ i_inv[s];
    end
  end

  assign o_y = (w_op[0] & w_op[1]) | (w_op[0] & w_op[2]) | (w_op[1] & w_op[2]);
endmodule

module mig_sweep_eval #(
  parameter int N_IN    = 7,
  parameter int N_NODES = 6,
  parameter int SEL_W   = $clog2(N_IN + N_NODES + 1),
  parameter int NODE_W  = (N_NODES > 1) ? $clog2(N_NODES) : 1,
  parameter int TT_W    = 1 << N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [NODE_W-1:0] cfg_node,
  input  logic [1:0]        cfg_slot,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic              cfg_inv,
  input  logic              eval_valid,
  output logic              eval_ready,
  input  logic [N_IN-1:0]   eval_vec,
  output logic              res_valid,
  output logic              res,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [TT_W-1:0]   tt,
  output logic [N_IN:0]     ones
);
  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t                         r_state, w_state_nxt;
  logic [N_NODES-1:0][2:0][SEL_W-1:0] r_sel;
  logic [N_NODES-1:0][2:0]        r_inv;
  logic [N_IN-1:0]                r_cnt;
  logic [TT_W-1:0]                r_tt;
  logic [N_IN:0]                  r_ones;
  logic                           r_done, r_res, r_res_valid;
  logic [N_IN-1:0]                w_pat;
  logic                           w_f, w_start, w_last, w_acc, w_cfg_ok, w_busy;

  assign w_busy     = (r_state == S_SWEEP);
  assign w_pat      = w_busy ? r_cnt : eval_vec;
  assign w_acc      = eval_valid & ~w_busy & ~start;
  assign w_cfg_ok   = cfg_we & ~w_busy & (cfg_slot != 2'd3) &
                      ({1'b0, cfg_node} < (NODE_W+1)'(N_NODES));

  // Each stage sees const 0, the pattern and only the nodes before it, so the
  // chain is acyclic by construction.
  for (genvar k = 0; k < N_NODES; k++) begin : g_node
    logic [N_IN+k:0] w_src;
    logic            w_out;
    if (k == 0) begin : g_first
      assign w_src = {w_pat, 1'b0};
    end else begin : g_rest
      assign w_src = {g_node[k-1].w_out, g_node[k-1].w_src};
    end
    mig_node #(.SRC_W(N_IN + k + 1), .SEL_W(SEL_W)) u_node (
      .i_src (w_src),
      .i_sel (r_sel[k]),
      .i_inv (r_inv[k]),
      .o_y   (w_out)
    );
  end

  assign w_f = g_node[N_NODES-1].w_out;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_start     = 1'b1;
        w_state_nxt = S_SWEEP;
      end
      S_SWEEP: if (r_cnt == '1) begin
        w_last      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tt    <= '0;
      r_ones  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_start) begin
        r_cnt  <= '0;
        r_tt   <= '0;
        r_ones <= '0;
      end else if (w_busy) begin
        r_tt[r_cnt] <= w_f;
        r_ones      <= r_ones + (N_IN+1)'(w_f);
        r_cnt       <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res       <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= w_acc;
      if (w_acc) r_res <= w_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
      r_inv <= '0;
    end else if (w_cfg_ok) begin
      for (int k = 0; k < N_NODES; k++)
        for (int s = 0; s < 3; s++)
          if (cfg_node == NODE_W'(k) && cfg_slot == 2'(s)) begin
            r_sel[k][s] <= cfg_sel;
            r_inv[k][s] <= cfg_inv;
          end
    end
  end

  assign busy       = w_busy;
  assign eval_ready = ~w_busy;
  assign done       = r_done;
  assign res        = r_res;
  assign res_valid  = r_res_valid;
  assign tt         = r_tt;
  assign ones       = r_ones;
endmodule

// File: tb/tb_mig_sweep_eval.sv
// Directed bench for mig_sweep_eval: sweeps, single evals, busy-phase
// robustness and reset mid-sweep, with hand-computed expectations.

module tb_mig_sweep_eval;
  localparam int N_IN = 7, N_NODES = 6, SEL_W = 4, NODE_W = 3, TT_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [NODE_W-1:0] cfg_node;
  logic [1:0]        cfg_slot;
  logic [SEL_W-1:0]  cfg_sel;
  logic              cfg_inv;
  logic              eval_valid, eval_ready;
  logic [N_IN-1:0]   eval_vec;
  logic              res_valid, res;
  logic              start, busy, done;
  logic [TT_W-1:0]   tt;
  logic [N_IN:0]     ones;

  int n_chk = 0;
  int n_err = 0;

  mig_sweep_eval #(.N_IN(N_IN), .N_NODES(N_NODES)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_node(cfg_node),
    .cfg_slot(cfg_slot), .cfg_sel(cfg_sel), .cfg_inv(cfg_inv),
    .eval_valid(eval_valid), .eval_ready(eval_ready), .eval_vec(eval_vec),
    .res_valid(res_valid), .res(res), .start(start), .busy(busy),
    .done(done), .tt(tt), .ones(ones)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cfg(input int node, input int slot, input int sel, input bit inv);
    cfg_we   = 1'b1;
    cfg_node = NODE_W'(node);
    cfg_slot = 2'(slot);
    cfg_sel  = SEL_W'(sel);
    cfg_inv  = inv;
    tick;
    cfg_we   = 1'b0;
  endtask

  // Nodes 1..5 forward the previous node: maj(n(k-1), n(k-1), 0).
  task automatic cfg_passthru;
    for (int k = 1; k < N_NODES; k++) begin
      cfg(k, 0, N_IN + k, 1'b0);
      cfg(k, 1, N_IN + k, 1'b0);
      cfg(k, 2, 0, 1'b0);
    end
  endtask

  task automatic sweep(input string tag);
    int n;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rdy"}, eval_ready, 0);
    n = 0;
    while (!done && n < 200) begin
      tick;
      n++;
    end
    chk({tag, "_len"}, n, 128);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic eval1(input logic [N_IN-1:0] v);
    eval_valid = 1'b1;
    eval_vec   = v;
    tick;
    eval_valid = 1'b0;
  endtask

  localparam logic [127:0] TT_MAJ = {16{8'hE8}};
  localparam logic [127:0] TT_X6  = {{64{1'b1}}, {64{1'b0}}};

  initial begin
    int n, n_done;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_node = '0; cfg_slot = '0; cfg_sel = '0;
    cfg_inv = 1'b0; eval_valid = 1'b0; eval_vec = '0; start = 1'b0;
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_tt", tt, 0);
    chk("rst_ones", ones, 0);
    chk("rst_rdy", eval_ready, 1);
    rst_n = 1'b1;
    tick;

    // Empty config: every node is const 0.
    sweep("s0");
    chk("s0_done", done, 1);
    chk("s0_tt", tt, 0);
    chk("s0_ones", ones, 0);
    tick;
    chk("s0_done_pulse", done, 0);

    // Node0 = maj(x0,x1,x2), forwarded to the output.
    cfg(0, 0, 1, 1'b0);
    cfg(0, 1, 2, 1'b0);
    cfg(0, 2, 3, 1'b0);
    cfg_passthru;
    sweep("s1");
    chk("s1_tt", tt, TT_MAJ);
    chk("s1_ones", ones, 64);
    // Back-to-back start accepted in the done cycle.
    sweep("s1b");
    chk("s1b_tt", tt, TT_MAJ);

    // Single evals, back to back.
    eval_valid = 1'b1;
    eval_vec   = 7'b0000011;
    tick;
    chk("ev0_rv", res_valid, 1);
    chk("ev0_res", res, 1);
    eval_vec = 7'b0000100;
    tick;
    chk("ev1_rv", res_valid, 1);
    chk("ev1_res", res, 0);
    eval_valid = 1'b0;
    tick;
    chk("ev2_rv", res_valid, 0);
    chk("ev2_res_hold", res, 0);

    // Node0 = maj(~0, x6, x6) = x6.
    cfg(0, 0, 0, 1'b1);
    cfg(0, 1, 7, 1'b0);
    cfg(0, 2, 7, 1'b0);
    sweep("s2");
    chk("s2_tt", tt, TT_X6);
    chk("s2_ones", ones, 64);
    cfg(5, 2, 0, 1'b1);
    sweep("s3");
    chk("s3_tt", tt, TT_X6);
    chk("s3_ones", ones, 64);

    // start and eval together: start wins, eval rejected.
    start = 1'b1; eval_valid = 1'b1; eval_vec = 7'b1000000;
    tick;
    start = 1'b0; eval_valid = 1'b0;
    chk("se_busy", busy, 1);
    chk("se_rv", res_valid, 0);
    chk("se_res", res, 0);
    // Busy-phase start, config write (would force output to 1) and eval ignored.
    n = 0;
    while (!done && n < 200) begin
      if (n == 5) begin
        chk("bz_rdy", eval_ready, 0);
        start = 1'b1; eval_valid = 1'b1; eval_vec = 7'b1000000;
        cfg_we = 1'b1; cfg_node = 3'd5; cfg_slot = 2'd0; cfg_sel = 4'd12; cfg_inv = 1'b1;
      end
      tick;
      n++;
      if (n == 6) begin
        chk("bz_rv", res_valid, 0);
        start = 1'b0; eval_valid = 1'b0; cfg_we = 1'b0;
      end
    end
    chk("bz_len", n, 128);
    chk("bz_tt", tt, TT_X6);
    chk("bz_ones", ones, 64);
    tick;
    chk("bz_no_restart", busy, 0);
    eval1(7'b0000000);
    chk("bz_cfg_kept0", res, 0);
    eval1(7'b1000000);
    chk("bz_cfg_kept1", res, 1);

    // Reset at pattern 40 with the majority function loaded.
    cfg(0, 0, 1, 1'b0);
    cfg(0, 1, 2, 1'b0);
    cfg(0, 2, 3, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 40; i++) tick;
    chk("mr_ones40", ones, 20);
    chk("mr_tt40", tt, {88'h0, 40'hE8E8E8E8E8});
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_tt", tt, 0);
    chk("mr_ones", ones, 0);
    chk("mr_rdy", eval_ready, 1);
    #2 rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 150; i++) begin
      tick;
      if (done) n_done++;
    end
    chk("mr_no_done", n_done, 0);
    chk("mr_idle", busy, 0);
    eval1(7'b1000111);
    chk("mr_cfg_lost_rv", res_valid, 1);
    chk("mr_cfg_lost", res, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
